// File: rtl/recip_denorm.sv
// recip_denorm: three-stage back-pressured denormalizing left shifter for the
// reciprocal datapath. Shifts the normalized mantissa left by the operand's
// leading-zero count and saturates to all ones on overflow or divide-by-zero.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   input handshake; in_ready = global advance
//   in_d  [WIDTH-1:0]   normalized mantissa
//   in_s  [4:0]         left-shift count
//   in_a                original operand was zero (forces saturation)
//   out_valid/out_ready output handshake
//   out_q [WIDTH-1:0]   denormalized result (all ones when saturated)
//   out_sat             result saturated
//
// Stages: S1 shifts by 16/8, S2 by 4/2, S3 by 1 and applies the final select.
// A sticky overflow flag travels with each beat so a bit lost in an early
// sub-step is never forgotten. WIDTH must stay within 17..32 so the 16-bit
// sub-step is meaningful and the 5-bit count covers the width.
module recip_denorm #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_d,
  input  logic [4:0]       in_s,
  input  logic             in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic             out_sat
);

  localparam logic [WIDTH-1:0] ONES = '1;

  // Conditional left shift by a fixed amount. MSB of the result is set when
  // any 1 bit falls off the top.
  function automatic logic [WIDTH:0] shl(input logic [WIDTH-1:0] d,
                                         input logic en, input int n);
    logic [WIDTH:0] r;
    r = {1'b0, d};
    if (en) begin
      r[WIDTH-1:0] = d << n;
      r[WIDTH]     = (d >> (WIDTH - n)) != '0;
    end
    return r;
  endfunction

  // Single global advance: the whole pipe moves or the whole pipe holds.
  logic adv;
  assign adv      = ~(out_valid & ~out_ready);
  assign in_ready = adv;

  logic [3:1]       vld_pipe;
  logic [WIDTH-1:0] d1, d2, q3;
  logic [2:0]       sh1;
  logic             sh2;
  logic             ov1, ov2, sat3;

  // S1 combinational: 16 then 8
  logic [WIDTH:0] s1_a, s1_b;
  assign s1_a = shl(in_d, in_s[4], 16);
  assign s1_b = shl(s1_a[WIDTH-1:0], in_s[3], 8);

  // S2 combinational: 4 then 2
  logic [WIDTH:0] s2_a, s2_b;
  assign s2_a = shl(d1, sh1[2], 4);
  assign s2_b = shl(s2_a[WIDTH-1:0], sh1[1], 2);

  // S3 combinational: 1 and final overflow
  logic [WIDTH:0] s3_a;
  logic           ov3;
  assign s3_a = shl(d2, sh2, 1);
  assign ov3  = ov2 | s3_a[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      d1       <= '0;
      d2       <= '0;
      q3       <= '0;
      sh1      <= '0;
      sh2      <= 1'b0;
      ov1      <= 1'b0;
      ov2      <= 1'b0;
      sat3     <= 1'b0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[2:1], in_valid};
      d1       <= s1_b[WIDTH-1:0];
      sh1      <= in_s[2:0];
      ov1      <= in_a | s1_a[WIDTH] | s1_b[WIDTH];
      d2       <= s2_b[WIDTH-1:0];
      sh2      <= sh1[0];
      ov2      <= ov1 | s2_a[WIDTH] | s2_b[WIDTH];
      q3       <= ov3 ? ONES : s3_a[WIDTH-1:0];
      sat3     <= ov3;
    end
  end

  assign out_valid = vld_pipe[3];
  assign out_q     = q3;
  assign out_sat   = sat3;

endmodule
